// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control and a 1 Hz tick enable.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and keep running.
module countdown_timer #(
   parameter int HOURS_MAX = 23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [4:0] set_hours,
   input  logic [5:0] set_mins,
   input  logic [5:0] set_secs,
   input  logic       start,
   input  logic       stop,
   input  logic       ack,
   output logic [4:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] H_MAX = 5'(HOURS_MAX);

   state_t     state;
   logic       count_zero;
   logic       count_one;
   logic [4:0] load_h;
   logic [5:0] load_m;
   logic [5:0] load_s;

   assign count_zero = (hours == 5'd0) && (mins == 6'd0) && (secs == 6'd0);
   assign count_one  = (hours == 5'd0) && (mins == 6'd0) && (secs == 6'd1);
   assign load_h     = (set_hours > H_MAX) ? H_MAX : set_hours;
   assign load_m     = (set_mins > 6'd59) ? 6'd59 : set_mins;
   assign load_s     = (set_secs > 6'd59) ? 6'd59 : set_secs;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [4:0] pre_h;
   logic [5:0] pre_m;
   logic [5:0] pre_s;
   logic       preset_zero;

   assign preset_zero = (pre_h == 5'd0) && (pre_m == 6'd0) && (pre_s == 6'd0);

   // Preset capture; only needed when expiry reloads the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_h <= 5'd0;
         pre_m <= 6'd0;
         pre_s <= 6'd0;
      end else if (load) begin
         pre_h <= load_h;
         pre_m <= load_m;
         pre_s <= load_s;
      end
   end
`endif

   // Control FSM and count; one action per clock, taken from the highest-priority qualifying input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hours   <= 5'd0;
         mins    <= 6'd0;
         secs    <= 6'd0;
         running <= 1'b0;
         done    <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            hours   <= load_h;
            mins    <= load_m;
            secs    <= load_s;
            state   <= IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
         end else if (stop && (state == RUN)) begin
            state   <= PAUSE;
            running <= 1'b0;
         end else if (start && ((state == IDLE) || (state == PAUSE)) && !count_zero) begin
            state   <= RUN;
            running <= 1'b1;
         end else if (ack && (state == DONE)) begin
            state <= IDLE;
            alarm <= 1'b0;
         end else if (tick && (state == RUN)) begin
            if (count_one) begin
               done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               if (!preset_zero) begin
                  hours <= pre_h;
                  mins  <= pre_m;
                  secs  <= pre_s;
               end else begin
                  secs    <= 6'd0;
                  state   <= DONE;
                  running <= 1'b0;
                  alarm   <= 1'b1;
               end
`else
               secs    <= 6'd0;
               state   <= DONE;
               running <= 1'b0;
               alarm   <= 1'b1;
`endif
            end else if (secs != 6'd0) begin
               secs <= secs - 6'd1;
            end else if (mins != 6'd0) begin
               secs <= 6'd59;
               mins <= mins - 6'd1;
            end else if (hours != 5'd0) begin
               secs  <= 6'd59;
               mins  <= 6'd59;
               hours <= hours - 5'd1;
            end else begin
               secs <= 6'd0;
            end
         end else begin
            state <= state;
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: total-seconds reference model, directed literal checks,
// then randomized stimulus. Honours COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

   localparam int HMAX = 23;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic       clk;
   logic       reset, tick, load, start, stop, ack;
   logic [4:0] set_hours;
   logic [5:0] set_mins, set_secs;
   logic [4:0] hours;
   logic [5:0] mins, secs;
   logic       running, done, alarm;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   int m_rem = 0, m_preset = 0, m_st = S_IDLE, m_done = 0;

   countdown_timer #(.HOURS_MAX(HMAX)) dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .set_hours(set_hours), .set_mins(set_mins), .set_secs(set_secs),
      .start(start), .stop(stop), .ack(ack),
      .hours(hours), .mins(mins), .secs(secs),
      .running(running), .done(done), .alarm(alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the count is a single number of seconds remaining.
   always @(posedge clk) begin : model
      int rem, pre, st, dn, h, m, s;
      rem = m_rem; pre = m_preset; st = m_st; dn = 0;
      if (reset) begin
         rem = 0; pre = 0; st = S_IDLE;
      end else if (load) begin
         h = (int'(set_hours) > HMAX) ? HMAX : int'(set_hours);
         m = (int'(set_mins) > 59) ? 59 : int'(set_mins);
         s = (int'(set_secs) > 59) ? 59 : int'(set_secs);
         rem = h * 3600 + m * 60 + s;
         pre = rem;
         st = S_IDLE;
      end else if (stop && st == S_RUN) begin
         st = S_PAUSE;
      end else if (start && (st == S_IDLE || st == S_PAUSE) && rem != 0) begin
         st = S_RUN;
      end else if (ack && st == S_DONE) begin
         st = S_IDLE;
      end else if (tick && st == S_RUN) begin
         rem = rem - 1;
         if (rem == 0) begin
            dn = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (pre != 0) rem = pre;
            else st = S_DONE;
`else
            st = S_DONE;
`endif
         end
      end
      m_rem <= rem; m_preset <= pre; m_st <= st; m_done <= dn;
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("hours",   int'(hours),   m_rem / 3600);
         chk("mins",    int'(mins),    (m_rem / 60) % 60);
         chk("secs",    int'(secs),    m_rem % 60);
         chk("running", int'(running), int'(m_st == S_RUN));
         chk("alarm",   int'(alarm),   int'(m_st == S_DONE));
         chk("done",    int'(done),    m_done);
         chk("range",   int'(m_rem <= HMAX * 3600 + 3599), 1);
      end
   end

   // Drive one clock of inputs (from negedge to next negedge).
   task automatic cyc(input bit r, input bit l, input bit st, input bit sp, input bit a, input bit t);
      reset = r; load = l; start = st; stop = sp; ack = a; tick = t;
      @(negedge clk);
   endtask

   task automatic do_load(input int h, input int m, input int s);
      set_hours = 5'(h); set_mins = 6'(m); set_secs = 6'(s);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic lit(input string name, input int h, input int m, input int s);
      chk({name, "_h"}, int'(hours), h);
      chk({name, "_m"}, int'(mins), m);
      chk({name, "_s"}, int'(secs), s);
      chk({name, "_model"}, m_rem, h * 3600 + m * 60 + s);
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; tick = 1'b0;
      set_hours = 5'd0; set_mins = 6'd0; set_secs = 6'd0;
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      lit("reset", 0, 0, 0);
      chk("reset_flags", {running, done, alarm}, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      do_load(0, 0, 3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("run_after_start", int'(running), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("t1", 0, 0, 2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("t2", 0, 0, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("t3", 0, 0, 0);
      chk("done_pulse", int'(done), 1);
      chk("alarm_set", int'(alarm), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("done_cleared", int'(done), 0);
      lit("no_underflow", 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("alarm_acked", int'(alarm), 0);
      chk("idle_after_ack", int'(running), 0);
`else
      do_load(0, 0, 2);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("ar1", 0, 0, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("ar2", 0, 0, 2);
      chk("ar_done1", int'(done), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("ar3", 0, 0, 1);
      chk("ar_done_low", int'(done), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("ar4", 0, 0, 2);
      chk("ar_done2", int'(done), 1);
      chk("ar_alarm", int'(alarm), 0);
      chk("ar_running", int'(running), 1);
`endif

      do_load(1, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("hour_borrow", 0, 59, 59);
      do_load(0, 1, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("min_borrow", 0, 0, 59);

      do_load(30, 63, 63); lit("clamp", 23, 59, 59);
      chk("load_idle", int'(running), 0);
      do_load(0, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_zero_ignored", int'(running), 0);

      do_load(0, 0, 12);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("pre_stop", 0, 0, 10);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("paused", int'(running), 0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      lit("held", 0, 0, 10);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); lit("resume", 0, 0, 10);
      chk("resumed", int'(running), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("after_resume", 0, 0, 9);

      do_load(0, 5, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); lit("mid_run", 0, 5, 0);
      set_hours = 5'd7; set_mins = 6'd7; set_secs = 6'd7;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); lit("reset_mid_run", 0, 0, 0);
      chk("reset_flags2", {running, done, alarm}, 0);

      // Randomized phase: short presets so expiry, ack and pause are all exercised.
      for (int i = 0; i < 4000; i++) begin
         bit r, l, st, sp, a, t;
         r  = ($urandom_range(0, 299) == 0);
         l  = ($urandom_range(0, 39) == 0);
         st = ($urandom_range(0, 7) == 0);
         sp = ($urandom_range(0, 19) == 0);
         a  = ($urandom_range(0, 7) == 0);
         t  = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) == 0) begin
            set_hours = 5'($urandom_range(0, 31));
            set_mins  = 6'($urandom_range(0, 63));
            set_secs  = 6'($urandom_range(0, 63));
         end else begin
            set_hours = 5'd0;
            set_mins  = 6'($urandom_range(0, 1));
            set_secs  = 6'($urandom_range(0, 63));
         end
         cyc(r, l, st, sp, a, t);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
